// File: rtl/radix_4_iter_stage.sv
// radix_4_iter_stage: carry-save remainder update and on-the-fly quotient conversion for the radix-4 SRT divider
module radix_4_iter_stage #(
    parameter int WIDTH     = 32,
    parameter int ITN_WIDTH = WIDTH + 4,
    parameter int CNT_WIDTH = $clog2(WIDTH / 2 + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid_i,
    output logic                 start_ready_o,
    input  logic [ITN_WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    input  logic [CNT_WIDTH-1:0] iter_num_i,
    input  logic [4:0]           quot_digit_i,
    output logic [ITN_WIDTH-1:0] rem_sum_o,
    output logic [ITN_WIDTH-1:0] rem_carry_o,
    output logic [WIDTH-1:0]     divisor_o,
    output logic [4:0]           prev_quot_digit_o,
    output logic                 iter_en_o,
    output logic                 finish_valid_o,
    input  logic                 finish_ready_i,
    output logic [WIDTH-1:0]     quot_o,
    output logic [WIDTH-1:0]     quot_m1_o,
    output logic                 digit_err_o
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [ITN_WIDTH-1:0] r_sum, r_carry;
    logic [WIDTH-1:0]     r_div, r_q, r_qm;
    logic [4:0]           r_prev;
    logic                 r_err;
    logic                 w_legal;
    logic [4:0]           w_dig;
    logic [ITN_WIDTH-1:0] w_d, w_d2, w_add, w_s4, w_c4, w_csa_s, w_csa_m;
    logic [WIDTH-1:0]     w_q_nxt, w_qm_nxt;

    assign start_ready_o     = r_state == IDLE;
    assign iter_en_o         = r_state == ITER;
    assign finish_valid_o    = r_state == DONE;
    assign rem_sum_o         = r_sum;
    assign rem_carry_o       = r_carry;
    assign divisor_o         = r_div;
    assign prev_quot_digit_o = r_prev;
    assign quot_o            = r_q;
    assign quot_m1_o         = r_qm;
    assign digit_err_o       = r_err;

    // sanitise the digit, pick the addend and run the 3:2 compressor plus OTFC next values
    always_comb begin
        w_legal  = $onehot(quot_digit_i);
        w_dig    = w_legal ? quot_digit_i : 5'b00100;
        w_d      = {1'b0, r_div, 3'b000};
        w_d2     = {r_div, 4'b0000};
        w_add    = w_dig[0] ? w_d2 : w_dig[1] ? w_d : w_dig[3] ? ~w_d : w_dig[4] ? ~w_d2 : '0;
        w_s4     = {r_sum[ITN_WIDTH-3:0], 2'b00};
        w_c4     = {r_carry[ITN_WIDTH-3:0], 2'b00};
        w_csa_s  = w_s4 ^ w_c4 ^ w_add;
        w_csa_m  = (w_s4 & w_c4) | (w_s4 & w_add) | (w_c4 & w_add);
        w_q_nxt  = w_dig[0] ? {r_qm[WIDTH-3:0], 2'b10} : w_dig[1] ? {r_qm[WIDTH-3:0], 2'b11} :
                   w_dig[2] ? {r_q[WIDTH-3:0], 2'b00}  : w_dig[3] ? {r_q[WIDTH-3:0], 2'b01}  :
                   {r_q[WIDTH-3:0], 2'b10};
        w_qm_nxt = w_dig[0] ? {r_qm[WIDTH-3:0], 2'b01} : w_dig[1] ? {r_qm[WIDTH-3:0], 2'b10} :
                   w_dig[2] ? {r_qm[WIDTH-3:0], 2'b11} : w_dig[3] ? {r_q[WIDTH-3:0], 2'b00}  :
                   {r_q[WIDTH-3:0], 2'b01};
    end

    // control FSM with remainder, quotient and error state updated alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_qm    <= '0;
            r_prev  <= 5'b00100;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_valid_i) begin
                    r_sum   <= dividend_i;
                    r_carry <= '0;
                    r_div   <= divisor_i;
                    r_q     <= '0;
                    r_qm    <= '0;
                    r_prev  <= 5'b00100;
                    r_cnt   <= iter_num_i;
                    r_err   <= 1'b0;
                    r_state <= (iter_num_i == '0) ? DONE : ITER;
                end
                ITER: begin
                    r_sum   <= w_csa_s;
                    r_carry <= {w_csa_m[ITN_WIDTH-2:0], w_dig[3] | w_dig[4]};
                    r_q     <= w_q_nxt;
                    r_qm    <= w_qm_nxt;
                    r_prev  <= w_dig;
                    r_cnt   <= r_cnt - 1'b1;
                    r_err   <= r_err | ~w_legal;
                    if (r_cnt == CNT_WIDTH'(1)) r_state <= DONE;
                end
                DONE: if (finish_ready_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
